// File: rtl/vlane_shifter_pipe.sv
// Purpose: pipelined barrel shifter (SLL/SRL/SRA/ROL/ROR), shift split across STAGES registered stages.
// Latency: exactly STAGES enabled cycles from operand acceptance to result/out_valid.
// Backpressure: en=0 freezes every stage register; squash clears all valid bits regardless of en.
//
// Ports:
//   clk, resetn        clock, asynchronous active-low reset
//   en, squash         pipeline advance, synchronous valid clear
//   in_valid, opB, sa, op   operand, shift amount, operation code
//   out_valid, result  final-stage valid bit and data register
module vlane_shifter_pipe #(
    parameter int WIDTH     = 32,
    parameter int LOG2WIDTH = 5,
    parameter int STAGES    = 2
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 en,
    input  logic                 squash,
    input  logic                 in_valid,
    input  logic [WIDTH-1:0]     opB,
    input  logic [LOG2WIDTH-1:0] sa,
    input  logic [2:0]           op,
    output logic                 out_valid,
    output logic [WIDTH-1:0]     result
);

    // Shift-amount bits consumed per stage, most significant bits first.
    localparam int B = (LOG2WIDTH + STAGES - 1) / STAGES;

    localparam logic [2:0] OP_SRL = 3'b001;
    localparam logic [2:0] OP_SRA = 3'b011;
    localparam logic [2:0] OP_ROL = 3'b100;
    localparam logic [2:0] OP_ROR = 3'b101;

    // Select the sa bits handled by stage s. Trailing stages can own an empty
    // range; their mask is zero so they simply pass data through.
    function automatic logic [LOG2WIDTH-1:0] stage_mask(input int s);
        logic [LOG2WIDTH-1:0] m;
        int hi;
        int lo;
        hi = LOG2WIDTH - 1 - s * B;
        lo = LOG2WIDTH - (s + 1) * B;
        if (lo < 0) lo = 0;
        for (int i = 0; i < LOG2WIDTH; i++) begin
            m[i] = (i <= hi) && (i >= lo);
        end
        return m;
    endfunction

    // One partial shift. SRA fills from the carried original sign bit rather
    // than the current MSB so partial stages compose into a single-step SRA.
    function automatic logic [WIDTH-1:0] shift_step(
        input logic [WIDTH-1:0]     d,
        input logic [LOG2WIDTH-1:0] amt,
        input logic [2:0]           code,
        input logic                 sign
    );
        logic [2*WIDTH-1:0] wide;
        logic [WIDTH-1:0]   r;
        case (code)
            OP_SRL: r = d >> amt;
            OP_SRA: begin
                wide = {{WIDTH{sign}}, d} >> amt;
                r    = wide[WIDTH-1:0];
            end
            OP_ROL: begin
                wide = {d, d} << amt;
                r    = wide[2*WIDTH-1:WIDTH];
            end
            OP_ROR: begin
                wide = {d, d} >> amt;
                r    = wide[WIDTH-1:0];
            end
            default: r = d << amt;
        endcase
        return r;
    endfunction

    // Stage registers.
    logic [WIDTH-1:0]     dat_q  [STAGES];
    logic [LOG2WIDTH-1:0] sa_q   [STAGES];
    logic [2:0]           op_q   [STAGES];
    logic                 sign_q [STAGES];
    logic                 vld_q  [STAGES];

    // Per-stage inputs: ports for stage 0, previous stage registers otherwise.
    logic [WIDTH-1:0]     in_dat  [STAGES];
    logic [LOG2WIDTH-1:0] in_sa   [STAGES];
    logic [2:0]           in_op   [STAGES];
    logic                 in_sign [STAGES];
    logic                 in_vld  [STAGES];
    logic [WIDTH-1:0]     nxt_dat [STAGES];

    always_comb begin
        in_dat[0]  = opB;
        in_sa[0]   = sa;
        in_op[0]   = op;
        in_sign[0] = opB[WIDTH-1];
        in_vld[0]  = in_valid;
        for (int s = 1; s < STAGES; s++) begin
            in_dat[s]  = dat_q[s-1];
            in_sa[s]   = sa_q[s-1];
            in_op[s]   = op_q[s-1];
            in_sign[s] = sign_q[s-1];
            in_vld[s]  = vld_q[s-1];
        end
        for (int s = 0; s < STAGES; s++) begin
            nxt_dat[s] = shift_step(in_dat[s], in_sa[s] & stage_mask(s), in_op[s], in_sign[s]);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int s = 0; s < STAGES; s++) begin
                dat_q[s]  <= '0;
                sa_q[s]   <= '0;
                op_q[s]   <= '0;
                sign_q[s] <= 1'b0;
                vld_q[s]  <= 1'b0;
            end
        end else begin
            for (int s = 0; s < STAGES; s++) begin
                // squash wins over en so a stalled pipe can still be flushed.
                if (squash) begin
                    vld_q[s] <= 1'b0;
                end else if (en) begin
                    vld_q[s] <= in_vld[s];
                end
                if (en) begin
                    dat_q[s]  <= nxt_dat[s];
                    sa_q[s]   <= in_sa[s] & ~stage_mask(s);
                    op_q[s]   <= in_op[s];
                    sign_q[s] <= in_sign[s];
                end
            end
        end
    end

    assign out_valid = vld_q[STAGES-1];
    assign result    = dat_q[STAGES-1];

endmodule

// File: tb/tb_vlane_shifter_pipe.sv
// Purpose: directed and random checks of vlane_shifter_pipe for STAGES=1..5 driven in parallel.
// Latency: expectations placed STAGES enabled cycles after acceptance.
// Backpressure: exercises en stalls, squash and mid-stream reset.
module tb_vlane_shifter_pipe;

    logic        clk;
    logic        resetn;
    logic        en;
    logic        squash;
    logic        in_valid;
    logic [31:0] opB;
    logic [4:0]  sa;
    logic [2:0]  op;
    logic        vld [5];
    logic [31:0] res [5];

    int total  = 0;
    int passed = 0;
    int failed = 0;

    localparam int N = 40;
    logic [31:0] exp_r [N];

    // Index 1 is the default STAGES=2 configuration used by the directed steps.
    for (genvar g = 0; g < 5; g++) begin : g_dut
        vlane_shifter_pipe #(.WIDTH(32), .LOG2WIDTH(5), .STAGES(g + 1)) u_dut (
            .clk       (clk),
            .resetn    (resetn),
            .en        (en),
            .squash    (squash),
            .in_valid  (in_valid),
            .opB       (opB),
            .sa        (sa),
            .op        (op),
            .out_valid (vld[g]),
            .result    (res[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bit-by-bit single-step reference.
    function automatic logic [31:0] ref_shift(input logic [2:0] c, input logic [31:0] b, input logic [4:0] amt);
        logic [31:0] r;
        int k;
        k = int'(amt);
        for (int i = 0; i < 32; i++) begin
            case (c)
                3'b001:  r[i] = (i + k < 32) ? b[i+k] : 1'b0;
                3'b011:  r[i] = (i + k < 32) ? b[i+k] : b[31];
                3'b100:  r[i] = b[(i - k + 32) % 32];
                3'b101:  r[i] = b[(i + k) % 32];
                default: r[i] = (i >= k) ? b[i-k] : 1'b0;
            endcase
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [2:0] c, input logic [31:0] b, input logic [4:0] amt);
        in_valid = v;
        op       = c;
        opB      = b;
        sa       = amt;
    endtask

    initial begin
        resetn = 1'b0; en = 1'b0; squash = 1'b0;
        drive(1'b0, 3'b000, 32'h0, 5'd0);
        #3;
        chk("reset_vld", {31'b0, vld[1]}, 32'h0);
        chk("reset_res", res[1], 32'h0);
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;
        en = 1'b1;

        // SRL with exact two-cycle latency.
        drive(1'b1, 3'b001, 32'hF000_0000, 5'd4);
        tick();
        drive(1'b0, 3'b000, 32'h0, 5'd0);
        chk("srl_lat1_vld", {31'b0, vld[1]}, 32'h0);
        tick();
        chk("srl_vld", {31'b0, vld[1]}, 32'h1);
        chk("srl_res", res[1], 32'h0F00_0000);

        // SRA / ROR / ROL back to back.
        drive(1'b1, 3'b011, 32'h8000_0000, 5'd31);
        tick();
        drive(1'b1, 3'b101, 32'h0000_0001, 5'd1);
        tick();
        chk("sra_res", res[1], 32'hFFFF_FFFF);
        drive(1'b1, 3'b100, 32'h8000_0001, 5'd4);
        tick();
        chk("ror_res", res[1], 32'h8000_0000);
        drive(1'b0, 3'b000, 32'h0, 5'd0);
        tick();
        chk("rol_res", res[1], 32'h0000_0018);
        chk("rol_vld", {31'b0, vld[1]}, 32'h1);
        tick();
        chk("drain_vld", {31'b0, vld[1]}, 32'h0);

        // Back-to-back SLL of 1 by 0..31: no bubbles.
        for (int k = 0; k < 33; k++) begin
            if (k < 32) drive(1'b1, 3'b000, 32'h1, 5'(k));
            else        drive(1'b0, 3'b000, 32'h0, 5'd0);
            tick();
            if (k >= 1) begin
                chk($sformatf("sll_seq_vld_%0d", k - 1), {31'b0, vld[1]}, 32'h1);
                chk($sformatf("sll_seq_res_%0d", k - 1), res[1], 32'h1 << (k - 1));
            end
        end
        tick();

        // Stall with a valid result at the output and another in stage 0.
        drive(1'b1, 3'b000, 32'h5, 5'd3);
        tick();
        drive(1'b1, 3'b001, 32'hA000_0000, 5'd8);
        tick();
        en = 1'b0;
        drive(1'b1, 3'b100, 32'hDEAD_BEEF, 5'd7);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("stall_vld_%0d", k), {31'b0, vld[1]}, 32'h1);
            chk($sformatf("stall_res_%0d", k), res[1], 32'h0000_0028);
        end
        en = 1'b1;
        drive(1'b0, 3'b000, 32'h0, 5'd0);
        tick();
        chk("resume_vld", {31'b0, vld[1]}, 32'h1);
        chk("resume_res", res[1], 32'h00A0_0000);
        tick();
        chk("resume_nodup", {31'b0, vld[1]}, 32'h0);

        // Squash with two operands in flight plus one presented the same cycle.
        drive(1'b1, 3'b000, 32'h1, 5'd1);
        tick();
        drive(1'b1, 3'b000, 32'h1, 5'd2);
        tick();
        squash = 1'b1;
        drive(1'b1, 3'b000, 32'h1, 5'd3);
        tick();
        squash = 1'b0;
        drive(1'b0, 3'b000, 32'h0, 5'd0);
        chk("squash_vld0", {31'b0, vld[1]}, 32'h0);
        tick();
        chk("squash_vld1", {31'b0, vld[1]}, 32'h0);
        tick();
        chk("squash_vld2", {31'b0, vld[1]}, 32'h0);

        // Squash while stalled.
        drive(1'b1, 3'b000, 32'h3, 5'd1);
        tick();
        drive(1'b0, 3'b000, 32'h0, 5'd0);
        en = 1'b0; squash = 1'b1;
        tick();
        en = 1'b1; squash = 1'b0;
        tick();
        chk("squash_stall_vld", {31'b0, vld[1]}, 32'h0);

        // Asynchronous reset mid-stream.
        drive(1'b1, 3'b001, 32'hFFFF_0000, 5'd4);
        tick();
        drive(1'b1, 3'b001, 32'h0F0F_0000, 5'd4);
        tick();
        #2 resetn = 1'b0;
        #1;
        chk("arst_vld", {31'b0, vld[1]}, 32'h0);
        chk("arst_res", res[1], 32'h0);
        drive(1'b0, 3'b000, 32'h0, 5'd0);
        tick();
        resetn = 1'b1;
        tick();
        chk("post_rst_vld0", {31'b0, vld[1]}, 32'h0);
        drive(1'b1, 3'b000, 32'h7, 5'd4);
        tick();
        drive(1'b0, 3'b000, 32'h0, 5'd0);
        chk("post_rst_vld1", {31'b0, vld[1]}, 32'h0);
        tick();
        chk("post_rst_new_vld", {31'b0, vld[1]}, 32'h1);
        chk("post_rst_new_res", res[1], 32'h0000_0070);

        // Random sweep across all STAGES variants.
        squash = 1'b1;
        tick();
        squash = 1'b0;
        for (int i = 0; i < N + 4; i++) begin
            if (i < N) begin
                logic [2:0]  c;
                logic [31:0] b;
                logic [4:0]  amt;
                c   = 3'($urandom_range(0, 7));
                b   = $urandom;
                amt = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
                exp_r[i] = ref_shift(c, b, amt);
                drive(1'b1, c, b, amt);
            end else begin
                drive(1'b0, 3'b000, 32'h0, 5'd0);
            end
            tick();
            for (int s = 1; s <= 5; s++) begin
                int j;
                j = i - (s - 1);
                if (j >= 0 && j < N) begin
                    chk($sformatf("rnd_s%0d_vld_%0d", s, j), {31'b0, vld[s-1]}, 32'h1);
                    chk($sformatf("rnd_s%0d_res_%0d", s, j), res[s-1], exp_r[j]);
                end
            end
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/vlane_shifter_pipe.md
VLANE_SHIFTER_PIPE -- requirements
Module: vlane_shifter_pipe

Interface
REQ-001 Parameter WIDTH, default 32: data operand width in bits.
REQ-002 Parameter LOG2WIDTH, default 5: shift-amount width; WIDTH SHALL equal 2**LOG2WIDTH.
REQ-003 Parameter STAGES, default 2: number of registered shift stages, legal range 1..LOG2WIDTH.
REQ-004 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-005 resetn  input  1  asynchronous, active-low reset.
REQ-006 en  input  1  pipeline advance; 0 SHALL hold every stage register, including valid bits.
REQ-007 squash  input  1  synchronous clear of all valid bits, qualified by nothing.
REQ-008 in_valid  input  1  operand present this cycle.
REQ-009 opB  input  WIDTH  operand to shift.
REQ-010 sa  input  LOG2WIDTH  shift amount, 0..WIDTH-1.
REQ-011 op  input  3  operation: 000 SLL, 001 SRL, 011 SRA, 100 ROL, 101 ROR; other codes SHALL behave as SLL.
REQ-012 out_valid  output  1  result valid.
REQ-013 result  output  WIDTH  shifted operand.

Function
REQ-014 Shift SHALL be split into STAGES registered stages; B = ceil(LOG2WIDTH/STAGES).
REQ-015 Stage s (0 = first) SHALL shift by the sa bits [LOG2WIDTH-1-s*B : max(LOG2WIDTH-(s+1)*B,0)], weighted by their binary positions; stages with an empty bit range SHALL pass data through.
REQ-016 Each stage SHALL register its data, its remaining sa bits, op and a valid bit; downstream stages SHALL use the registered copies only.
REQ-017 Latency SHALL be exactly STAGES cycles of en=1: an operand accepted at edge N with en=1 SHALL appear on result/out_valid after STAGES enabled edges.
REQ-018 Throughput SHALL be one operand per enabled cycle, with no bubbles inserted.
REQ-019 SLL/ROL SHALL fill vacated low bits with 0 or the rotated-out high bits respectively; SRL SHALL fill with 0; ROR SHALL fill with the rotated-out low bits.
REQ-020 SRA SHALL fill with opB[WIDTH-1] at every stage; the sign bit SHALL be carried with the data so multi-stage SRA equals a single-step SRA.
REQ-021 sa=0 SHALL return opB unchanged for every op.
REQ-022 When in_valid=0, stage-0 valid SHALL load 0; data registers MAY load but SHALL NOT cause out_valid=1.
REQ-023 squash=1 SHALL clear all valid bits at the next edge regardless of en; an operand presented in the same cycle SHALL be discarded.
REQ-024 en=0 with squash=0 SHALL freeze result and out_valid at their current values.
REQ-025 result SHALL be driven from the final stage register; out_valid SHALL be the final-stage valid bit.

Reset
REQ-026 resetn=0 SHALL immediately clear all valid bits, data, sa and op registers to 0, without waiting for a clock edge; out_valid=0 and result=0 while reset is held.
REQ-027 Reset asserted mid-operation SHALL discard all in-flight operands; the first out_valid after release SHALL correspond to an operand accepted after release.

Verification
REQ-028 STAGES=2, en=1, op=001, opB=0xF000_0000, sa=4 -> after 2 cycles out_valid=1, result=0x0F00_0000.
REQ-029 op=011, opB=0x8000_0000, sa=31 -> result=0xFFFF_FFFF; op=101, opB=0x0000_0001, sa=1 -> 0x8000_0000; op=100, opB=0x8000_0001, sa=4 -> 0x0000_0018.
REQ-030 Back-to-back SLL of 0x1 with sa=0..31 over 32 cycles -> 32 consecutive valid results 1<<k, no gaps.
REQ-031 In-flight operand, en=0 for 3 cycles -> result/out_valid frozen; resume -> result appears with no loss or duplication.
REQ-032 squash=1 with two operands in flight -> out_valid=0 on the next 2 cycles; resetn pulsed low mid-stream -> out_valid=0 immediately, with no stale result after release.
REQ-033 Sweep STAGES=1..5 against a single-cycle reference model on random op/opB/sa -> identical results at latency STAGES.
